// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared types and constants for the serial receiver
package usr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rx_state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/usr_rx_shifter.sv
// rtl/usr_rx_shifter.sv - WIDTH-bit receive shift register with load-first and direction
module usr_rx_shifter
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             dir_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // load clears stale bits from an aborted frame while inserting the first bit
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      if (dir_i == DIR_LSB_FIRST) data_d = {bit_i, {(WIDTH-1){1'b0}}};
      else                        data_d = {{(WIDTH-1){1'b0}}, bit_i};
    end else if (shift_i) begin
      if (dir_i == DIR_LSB_FIRST) data_d = {bit_i, data_q[WIDTH-1:1]};
      else                        data_d = {data_q[WIDTH-2:0], bit_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data_o = data_q;
  assign next_o = data_d;

endmodule

// File: rtl/usr_serial_rx.sv
// rtl/usr_serial_rx.sv - serial-to-parallel receiver; USR_RX_PARITY_CHECK_EN adds even-parity check
module usr_serial_rx
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             sof,
  input  logic             dir,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

  rx_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic             dir_q;
  logic [WIDTH-1:0] par_out_q;
  logic             par_valid_q;
  logic             overrun_q;
  logic             frame_err_q;

  logic             take;
  logic             shift_en;
  logic             last_bit;
  logic             word_done;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] sh_data;
  logic [WIDTH-1:0] sh_next;

  assign take     = ser_valid & sof;
  assign shift_en = ser_valid & ~sof & (state_q == SHIFT);
  assign last_bit = shift_en & (cnt_q == CW'(WIDTH - 1));

  usr_rx_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (take),
    .shift_i(shift_en),
    .dir_i  (take ? dir : dir_q),
    .bit_i  (ser_in),
    .data_o (sh_data),
    .next_o (sh_next)
  );

`ifdef USR_RX_PARITY_CHECK_EN
  logic par_bit;
  logic parity_ok;
  logic parity_err_q;

  assign par_bit    = ser_valid & ~sof & (state_q == PARITY);
  assign parity_ok  = ~(^sh_data ^ ser_in);
  assign word_done  = par_bit & parity_ok;
  assign word       = sh_data;
  assign parity_err = parity_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= par_bit & ~parity_ok;
  end
`else
  assign word_done  = last_bit;
  assign word       = sh_next;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dir_q       <= DIR_MSB_FIRST;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;

      // a completion in the accept cycle reloads the slot with no bubble
      if (par_valid_q && out_ready) par_valid_q <= 1'b0;
      if (word_done) begin
        if (par_valid_q && !out_ready) begin
          overrun_q <= 1'b1;
        end else begin
          par_out_q   <= word;
          par_valid_q <= 1'b1;
        end
      end

      if (take) begin
        if (state_q != IDLE) frame_err_q <= 1'b1;
        state_q <= SHIFT;
        cnt_q   <= CW'(1);
        dir_q   <= dir;
      end else begin
        case (state_q)
          SHIFT: begin
            if (shift_en) begin
              if (last_bit) begin
                cnt_q <= '0;
`ifdef USR_RX_PARITY_CHECK_EN
                state_q <= PARITY;
`else
                state_q <= IDLE;
`endif
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          PARITY: begin
            if (ser_valid) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign par_out   = par_out_q;
  assign par_valid = par_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_usr_serial_rx.sv
// tb/tb_usr_serial_rx.sv - scoreboard bench for usr_serial_rx against a bit-list reference model
module tb_usr_serial_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ser_in = 1'b0;
  logic         ser_valid = 1'b0;
  logic         sof = 1'b0;
  logic         dir = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] par_out;
  logic         par_valid;
  logic         busy;
  logic         overrun;
  logic         frame_err;
  logic         parity_err;

  int checks = 0;
  int failures = 0;
  bit rand_ready = 0;

  always #5 clk = ~clk;

  usr_serial_rx #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .sof       (sof),
    .dir       (dir),
    .par_out   (par_out),
    .par_valid (par_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits of the current frame kept as a list, word built arithmetically
  bit           frame_q[$];
  bit           in_frame = 0;
  bit           mdir = 0;
  bit           pending = 0;
  bit           exp_ovr = 0;
  bit           exp_ferr = 0;
  bit           exp_perr = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] assemble(input bit b[$], input bit d);
    longint w = 0;
    for (int i = 0; i < b.size(); i++)
      if (b[i]) w = w + (longint'(1) << (d ? i : (W - 1 - i)));
    return w[W-1:0];
  endfunction

  task automatic complete(input logic [W-1:0] w);
    if (pending) exp_ovr = 1;
    else begin
      exp_q.push_back(w);
      pending = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q.delete();
      exp_q.delete();
      in_frame = 0;
      pending = 0;
      exp_ovr = 0;
      exp_ferr = 0;
      exp_perr = 0;
    end else begin
      exp_ovr = 0;
      exp_ferr = 0;
      exp_perr = 0;
      if (pending && out_ready) pending = 0;
      if (ser_valid) begin
        if (sof) begin
          if (in_frame) exp_ferr = 1;
          frame_q = {ser_in};
          mdir = dir;
          in_frame = 1;
        end else if (in_frame) begin
          if (frame_q.size() < W) begin
            frame_q.push_back(ser_in);
`ifndef USR_RX_PARITY_CHECK_EN
            if (frame_q.size() == W) begin
              complete(assemble(frame_q, mdir));
              in_frame = 0;
            end
`endif
          end
`ifdef USR_RX_PARITY_CHECK_EN
          else begin
            int ones = int'(ser_in);
            foreach (frame_q[i]) ones += int'(frame_q[i]);
            if (ones % 2 == 0) complete(assemble(frame_q, mdir));
            else exp_perr = 1;
            in_frame = 0;
          end
`endif
        end
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {par_out, par_valid, busy, overrun, frame_err, parity_err}, 32'd0);
    end else begin
      chk("par_valid", par_valid, pending);
      chk("overrun", overrun, exp_ovr);
      chk("frame_err", frame_err, exp_ferr);
      chk("parity_err", parity_err, exp_perr);
      chk("busy", busy, in_frame);
      if (pending && out_ready) begin
        if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
        else chk("par_out", par_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    ser_valid = 1'b0;
    sof = 1'($urandom_range(0, 1));
    ser_in = 1'($urandom_range(0, 1));
    dir = 1'($urandom_range(0, 1));
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input bit b, input bit s, input bit d);
    ser_valid = 1'b1;
    ser_in = b;
    sof = s;
    dir = d;
    tick();
  endtask

  task automatic send_frame(input logic [W-1:0] word, input bit d, input int max_gap,
                            input int nbits, input bit bad_par);
    for (int i = 0; i < nbits; i++) begin
      send_bit(d ? word[i] : word[W-1-i], i == 0, (i == 0) ? d : 1'($urandom_range(0, 1)));
      if (max_gap > 0) gap($urandom_range(0, max_gap));
    end
`ifdef USR_RX_PARITY_CHECK_EN
    if (nbits == W) send_bit((^word) ^ bad_par, 1'b0, 1'($urandom_range(0, 1)));
`else
    if (bad_par) gap(0);
`endif
  endtask

  initial begin
    gap(3);
    rst_n = 1'b1;
    gap(2);

    out_ready = 1'b1;
    send_frame(8'hB2, 1'b0, 0, W, 1'b0);
    gap(3);
    send_frame(8'h4D, 1'b1, 3, W, 1'b0);
    gap(3);

    out_ready = 1'b0;
    send_frame(8'hB2, 1'b0, 0, W, 1'b0);
    send_frame(8'h5A, 1'b0, 0, W, 1'b0);
    gap(3);
    out_ready = 1'b1;
    gap(4);

    send_frame(8'hC3, 1'b0, 0, 3, 1'b0);
    send_frame(8'hB2, 1'b0, 0, W, 1'b0);
    gap(3);

`ifdef USR_RX_PARITY_CHECK_EN
    send_frame(8'hB2, 1'b0, 0, W, 1'b1);
    gap(3);
`endif

    out_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 0, W, 1'b0);
    send_frame(8'h96, 1'b0, 0, 4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {par_out, par_valid, busy, overrun, frame_err, parity_err}, 32'd0);
    gap(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    gap(1);
    send_frame(8'hE7, 1'b1, 0, W, 1'b0);
    gap(3);

    rand_ready = 1;
    repeat (60) begin
      int r = $urandom_range(0, 7);
      logic [W-1:0] w = W'($urandom);
      bit d = 1'($urandom_range(0, 1));
      if (r == 0) send_frame(w, d, 1, $urandom_range(1, W - 1), 1'b0);
      else if (r == 1) repeat ($urandom_range(1, 4)) send_bit(1'($urandom_range(0, 1)), 1'b0, d);
      else send_frame(w, d, $urandom_range(0, 2), W, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 4));
    end

    rand_ready = 0;
    out_ready = 1'b1;
    gap(3 * W);
    chk("drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
